// File: rtl/re_demapper.sv
// rtl/re_demapper.sv - reads the DMRS comb and data REs back from the resource grid
// and delivers them as one tagged stream behind a 2-entry output FIFO.
module re_demapper #(
    parameter int FFT_Len  = 18,
    parameter int Total_Sc = 1200
) (
    input  logic               CLK_RE,
    input  logic               RST_RE,
    input  logic               EN_RE,
    input  logic               Start,
    input  logic [10:0]        N_sc,
    input  logic [6:0]         N_rb,
    input  logic [3:0]         Sym_Start,
    input  logic [3:0]         Sym_End,
    output logic               Rd_en,
    output logic [10:0]        Rd_addr,
    output logic [3:0]         Rd_sym,
    input  logic [FFT_Len-1:0] Rd_I,
    input  logic [FFT_Len-1:0] Rd_Q,
    output logic [FFT_Len-1:0] Out_I,
    output logic [FFT_Len-1:0] Out_Q,
    output logic [10:0]        Out_Addr,
    output logic [3:0]         Out_Sym,
    output logic               Out_Is_Dmrs,
    output logic               Out_Valid,
    input  logic               Out_Ready,
    output logic               Sym_Done,
    output logic               Demap_Done,
    output logic               Busy,
    output logic               Cfg_Err
);

    // tag = {addr[10:0], sym[3:0], is_dmrs, last_of_symbol}
    localparam int TAG_W = 17;
    localparam int ENT_W = 2 * FFT_Len + TAG_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_RD_DMRS,
        S_RD_DATA,
        S_DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [10:0]      nsc_q, nsc_d;
    logic [6:0]       nrb_q, nrb_d;
    logic [3:0]       sym_start_q, sym_start_d;
    logic [3:0]       sym_end_q, sym_end_d;
    logic [10:0]      addr_q, addr_d;
    logic [3:0]       sym_q, sym_d;
    logic             rd_en_q, rd_en_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [ENT_W-1:0] fifo_q [2];
    logic [ENT_W-1:0] fifo_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;

    logic [11:0]      span;
    logic [11:0]      alloc_end;
    logic [11:0]      next_addr;
    logic [2:0]       slots;
    logic [ENT_W-1:0] head;
    logic             cfg_bad;
    logic             reading;
    logic             pop;
    logic             push;
    logic             issue;
    logic             last_in_sym;

    // 12-bit sums so N_sc + N_rb*12 cannot wrap before the range check.
    always_comb begin
        span        = 12'(nrb_q) * 12'd12;
        alloc_end   = 12'(nsc_q) + span;
        cfg_bad     = (nrb_q == 7'd0) || (alloc_end > 12'(Total_Sc)) ||
                      (sym_end_q <= sym_start_q) || (sym_end_q > 4'd13);
        reading     = (state_q == S_RD_DMRS) || (state_q == S_RD_DATA);
        head        = fifo_q[rd_ptr_q];
        pop         = (count_q != 2'd0) && Out_Ready;
        push        = rd_en_q;
        slots       = 3'(count_q) + 3'(rd_en_q) - 3'(pop);
        issue       = EN_RE && reading && (slots < 3'd2);
        next_addr   = 12'(addr_q) + ((state_q == S_RD_DMRS) ? 12'd2 : 12'd1);
        last_in_sym = (next_addr == alloc_end);
    end

    always_comb begin
        state_d     = state_q;
        nsc_d       = nsc_q;
        nrb_d       = nrb_q;
        sym_start_d = sym_start_q;
        sym_end_d   = sym_end_q;
        addr_d      = addr_q;
        sym_d       = sym_q;
        rd_en_d     = issue;
        tag_d       = tag_q;
        if (issue) begin
            tag_d = {addr_q, sym_q, state_q == S_RD_DMRS, last_in_sym};
        end
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    nsc_d       = N_sc;
                    nrb_d       = N_rb;
                    sym_start_d = Sym_Start;
                    sym_end_d   = Sym_End;
                    state_d     = S_CHECK;
                end
            end
            S_CHECK: begin
                if (cfg_bad) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RD_DMRS;
                    addr_d  = nsc_q;
                    sym_d   = sym_start_q;
                end
            end
            S_RD_DMRS: begin
                if (issue) begin
                    if (last_in_sym) begin
                        state_d = S_RD_DATA;
                        addr_d  = nsc_q;
                        sym_d   = sym_q + 4'd1;
                    end else begin
                        addr_d = next_addr[10:0];
                    end
                end
            end
            S_RD_DATA: begin
                if (issue) begin
                    if (last_in_sym) begin
                        addr_d = nsc_q;
                        if (sym_q == sym_end_q) begin
                            state_d = S_DRAIN;
                        end else begin
                            sym_d = sym_q + 4'd1;
                        end
                    end else begin
                        addr_d = next_addr[10:0];
                    end
                end
            end
            S_DRAIN: begin
                if ((count_q == 2'd0) && !rd_en_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The issue rule keeps occupancy plus in-flight at or below 2, so a push never meets a full FIFO.
    always_comb begin
        fifo_d = fifo_q;
        if (push) begin
            fifo_d[wr_ptr_q] = {Rd_I, Rd_Q, tag_q};
        end
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q + 2'(push) - 2'(pop);
    end

    always_ff @(posedge CLK_RE) begin
        if (RST_RE) begin
            state_q     <= S_IDLE;
            nsc_q       <= '0;
            nrb_q       <= '0;
            sym_start_q <= '0;
            sym_end_q   <= '0;
            addr_q      <= '0;
            sym_q       <= '0;
            rd_en_q     <= 1'b0;
            tag_q       <= '0;
            fifo_q[0]   <= '0;
            fifo_q[1]   <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            nsc_q       <= nsc_d;
            nrb_q       <= nrb_d;
            sym_start_q <= sym_start_d;
            sym_end_q   <= sym_end_d;
            addr_q      <= addr_d;
            sym_q       <= sym_d;
            rd_en_q     <= rd_en_d;
            tag_q       <= tag_d;
            fifo_q[0]   <= fifo_d[0];
            fifo_q[1]   <= fifo_d[1];
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    assign Rd_en       = issue;
    assign Rd_addr     = issue ? addr_q : 11'd0;
    assign Rd_sym      = issue ? sym_q : 4'd0;
    assign Out_I       = head[ENT_W-1 -: FFT_Len];
    assign Out_Q       = head[TAG_W +: FFT_Len];
    assign Out_Addr    = head[16:6];
    assign Out_Sym     = head[5:2];
    assign Out_Is_Dmrs = head[1];
    assign Out_Valid   = (count_q != 2'd0);
    assign Sym_Done    = pop && head[0];
    assign Demap_Done  = (state_q == S_DRAIN) && (count_q == 2'd0) && !rd_en_q;
    assign Busy        = ((state_q == S_CHECK) && !cfg_bad) || reading || (state_q == S_DRAIN);
    assign Cfg_Err     = (state_q == S_CHECK) && cfg_bad;

endmodule

// File: tb/tb_re_demapper.sv
// tb/tb_re_demapper.sv - randomized bench for re_demapper against a grid-walk reference model
module tb_re_demapper;

    logic        clk = 1'b0;
    logic        RST_RE, EN_RE, Start, Out_Ready;
    logic [10:0] N_sc;
    logic [6:0]  N_rb;
    logic [3:0]  Sym_Start, Sym_End;
    logic        Rd_en;
    logic [10:0] Rd_addr;
    logic [3:0]  Rd_sym;
    logic [17:0] Rd_I, Rd_Q, Out_I, Out_Q;
    logic [10:0] Out_Addr;
    logic [3:0]  Out_Sym;
    logic        Out_Is_Dmrs, Out_Valid, Sym_Done, Demap_Done, Busy, Cfg_Err;

    always #5 clk = ~clk;

    re_demapper #(.FFT_Len(18), .Total_Sc(1200)) dut (
        .CLK_RE(clk), .RST_RE(RST_RE), .EN_RE(EN_RE), .Start(Start),
        .N_sc(N_sc), .N_rb(N_rb), .Sym_Start(Sym_Start), .Sym_End(Sym_End),
        .Rd_en(Rd_en), .Rd_addr(Rd_addr), .Rd_sym(Rd_sym), .Rd_I(Rd_I), .Rd_Q(Rd_Q),
        .Out_I(Out_I), .Out_Q(Out_Q), .Out_Addr(Out_Addr), .Out_Sym(Out_Sym),
        .Out_Is_Dmrs(Out_Is_Dmrs), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .Sym_Done(Sym_Done), .Demap_Done(Demap_Done), .Busy(Busy), .Cfg_Err(Cfg_Err)
    );

    typedef struct {
        logic [17:0] i;
        logic [17:0] q;
        logic [10:0] addr;
        logic [3:0]  sym;
        logic        dmrs;
        logic        last;
    } re_t;

    re_t exp_q[$];
    re_t got_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int outstanding, occ_viol, stall_viol, same_viol, spur_sd;
    int sym_done_cnt, demap_cnt, demap_cyc, cfg_cnt, busy_cnt, rd_cnt;
    int first_rd, first_ov, last_acc, start_cyc, bad_idx;
    logic        stall_prev;
    logic [51:0] stall_snap;
    logic [10:0] last_rd_addr;
    logic [3:0]  last_rd_sym;
    logic [31:0] gseed;

    function automatic logic [17:0] gi(input logic [3:0] s, input logic [10:0] a);
        return 18'(32'(a) * 23 + 32'(s) * 2741 + gseed);
    endfunction

    function automatic logic [17:0] gq(input logic [3:0] s, input logic [10:0] a);
        return 18'((32'(a) * 389) ^ (32'(s) * 77) ^ (gseed >> 3));
    endfunction

    always @(posedge clk) cyc = cyc + 1;

    // Grid memory: data for a read appears one cycle after Rd_en; garbage otherwise.
    always @(posedge clk) begin
        if (Rd_en) begin
            Rd_I         <= gi(Rd_sym, Rd_addr);
            Rd_Q         <= gq(Rd_sym, Rd_addr);
            last_rd_addr <= Rd_addr;
            last_rd_sym  <= Rd_sym;
        end else begin
            Rd_I <= 18'($urandom);
            Rd_Q <= 18'($urandom);
        end
    end

    always @(negedge clk) begin
        if (RST_RE) begin
            outstanding = 0;
            stall_prev  = 1'b0;
        end else begin
            re_t r;
            logic pop_now;
            pop_now = Out_Valid && Out_Ready;
            if (outstanding > 2) occ_viol++;
            if (stall_prev && (!Out_Valid ||
                {Out_I, Out_Q, Out_Addr, Out_Sym, Out_Is_Dmrs} !== stall_snap)) stall_viol++;
            stall_prev = Out_Valid && !Out_Ready;
            stall_snap = {Out_I, Out_Q, Out_Addr, Out_Sym, Out_Is_Dmrs};
            if (Out_Valid && first_ov < 0) first_ov = cyc;
            if (pop_now) begin
                r.i = Out_I; r.q = Out_Q; r.addr = Out_Addr; r.sym = Out_Sym;
                r.dmrs = Out_Is_Dmrs; r.last = Sym_Done;
                got_q.push_back(r);
                last_acc = cyc;
            end
            if (Rd_en) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = cyc;
            end
            if (Sym_Done && !pop_now) spur_sd++;
            if (Sym_Done) sym_done_cnt++;
            if (Sym_Done && Demap_Done) same_viol++;
            if (Demap_Done) begin
                demap_cnt++;
                demap_cyc = cyc;
            end
            if (Cfg_Err) cfg_cnt++;
            if (Busy) busy_cnt++;
            outstanding = outstanding + int'(Rd_en) - int'(pop_now);
        end
    end

    task automatic clear_mon();
        got_q.delete();
        occ_viol = 0; stall_viol = 0; same_viol = 0; spur_sd = 0;
        sym_done_cnt = 0; demap_cnt = 0; demap_cyc = -1; cfg_cnt = 0;
        busy_cnt = 0; rd_cnt = 0; first_rd = -1; first_ov = -1; last_acc = -1;
    endtask

    // Reference: DMRS comb N_sc+2k on Sym_Start, then every RE of each later symbol.
    task automatic build_exp(input int nsc, input int nrb, input int ss, input int se);
        re_t r;
        exp_q.delete();
        for (int k = 0; k < nrb * 6; k++) begin
            r.addr = 11'(nsc + 2 * k); r.sym = 4'(ss); r.dmrs = 1'b1;
            r.last = (k == nrb * 6 - 1);
            r.i = gi(r.sym, r.addr); r.q = gq(r.sym, r.addr);
            exp_q.push_back(r);
        end
        for (int s = ss + 1; s <= se; s++) begin
            for (int a = 0; a < nrb * 12; a++) begin
                r.addr = 11'(nsc + a); r.sym = 4'(s); r.dmrs = 1'b0;
                r.last = (a == nrb * 12 - 1);
                r.i = gi(r.sym, r.addr); r.q = gq(r.sym, r.addr);
                exp_q.push_back(r);
            end
        end
    endtask

    function automatic int stream_errs();
        int n = 0;
        bad_idx = -1;
        if (got_q.size() != exp_q.size()) n++;
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            if (got_q[k].i !== exp_q[k].i || got_q[k].q !== exp_q[k].q ||
                got_q[k].addr !== exp_q[k].addr || got_q[k].sym !== exp_q[k].sym ||
                got_q[k].dmrs !== exp_q[k].dmrs || got_q[k].last !== exp_q[k].last) begin
                n++;
                if (bad_idx < 0) bad_idx = k;
            end
        end
        return n;
    endfunction

    task automatic drive_modes(input int rmode, input int emode, input int n);
        case (rmode)
            0:       Out_Ready = 1'b1;
            1:       Out_Ready = (n % 2 == 0);
            default: Out_Ready = ($urandom_range(0, 9) < 6);
        endcase
        EN_RE = (emode == 0) ? 1'b1 : ($urandom_range(0, 9) != 0);
    endtask

    task automatic run_job(input int nsc, input int nrb, input int ss, input int se,
                           input int rmode, input int emode, input int bs_at, input int budget);
        int n;
        clear_mon();
        @(posedge clk); #1;
        N_sc = 11'(nsc); N_rb = 7'(nrb); Sym_Start = 4'(ss); Sym_End = 4'(se);
        Start = 1'b1;
        start_cyc = cyc;
        drive_modes(rmode, emode, 0);
        n = 1;
        while (demap_cnt == 0 && n < budget) begin
            @(posedge clk); #1;
            Start = (n == bs_at);
            N_sc = 11'($urandom); N_rb = 7'($urandom);
            Sym_Start = 4'($urandom); Sym_End = 4'($urandom);
            drive_modes(rmode, emode, n);
            n++;
        end
        Start = 1'b0; Out_Ready = 1'b1; EN_RE = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        RST_RE = 1'b1; EN_RE = 1'b0; Start = 1'b0; Out_Ready = 1'b0;
        N_sc = '0; N_rb = '0; Sym_Start = '0; Sym_End = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({Rd_en, Rd_addr, Rd_sym, Out_I, Out_Q, Out_Addr, Out_Sym, Out_Is_Dmrs,
             Out_Valid, Sym_Done, Demap_Done, Busy, Cfg_Err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b busy=%b rd_en=%b out_i=%h, all required 0",
                     Out_Valid, Busy, Rd_en, Out_I);
        end
        @(posedge clk); #1;
        RST_RE = 1'b0;
    endtask

    task automatic test_basic();
        int e;
        gseed = $urandom;
        build_exp(0, 1, 2, 3);
        run_job(0, 1, 2, 3, 0, 0, -1, 200);
        checks++; if (demap_cnt !== 1) begin errors++; $display("FAIL basic_demap_cnt: got %0d exp 1", demap_cnt); end
        e = stream_errs();
        checks++; if (e !== 0) begin errors++; $display("FAIL basic_stream: bad=%0d idx=%0d got_n=%0d exp_n=%0d", e, bad_idx, got_q.size(), exp_q.size()); end
        checks++; if (sym_done_cnt !== 2) begin errors++; $display("FAIL basic_sym_done: got %0d exp 2", sym_done_cnt); end
        checks++; if (first_rd - start_cyc !== 2) begin errors++; $display("FAIL basic_rd_latency: got %0d exp 2", first_rd - start_cyc); end
        checks++; if (first_ov - first_rd !== 2) begin errors++; $display("FAIL basic_out_latency: got %0d exp 2", first_ov - first_rd); end
        checks++; if (last_acc - first_ov !== 17) begin errors++; $display("FAIL basic_back_to_back: got %0d exp 17", last_acc - first_ov); end
        checks++; if (demap_cyc - last_acc !== 1) begin errors++; $display("FAIL basic_demap_timing: got %0d exp 1", demap_cyc - last_acc); end
        checks++; if (busy_cnt !== demap_cyc - start_cyc) begin errors++; $display("FAIL basic_busy_len: got %0d exp %0d", busy_cnt, demap_cyc - start_cyc); end
    endtask

    task automatic test_odd_nsc();
        int e, nd;
        gseed = $urandom;
        build_exp(13, 2, 0, 1);
        run_job(13, 2, 0, 1, 0, 0, -1, 300);
        e = stream_errs();
        checks++; if (e !== 0) begin errors++; $display("FAIL odd_stream: bad=%0d idx=%0d got_n=%0d exp_n=%0d", e, bad_idx, got_q.size(), exp_q.size()); end
        nd = 0;
        foreach (got_q[k]) if (got_q[k].dmrs) nd++;
        checks++; if (nd !== 12) begin errors++; $display("FAIL odd_dmrs_count: got %0d exp 12", nd); end
        checks++; if (last_acc - first_ov !== 35) begin errors++; $display("FAIL odd_back_to_back: got %0d exp 35", last_acc - first_ov); end
    endtask

    task automatic test_stall();
        int e;
        for (int pass = 0; pass < 2; pass++) begin
            gseed = $urandom;
            build_exp(0, 1, 2, 3);
            run_job(0, 1, 2, 3, pass + 1, pass, -1, 600);
            e = stream_errs();
            checks++; if (e !== 0) begin errors++; $display("FAIL stall_stream_%0d: bad=%0d idx=%0d got_n=%0d", pass, e, bad_idx, got_q.size()); end
            checks++; if (stall_viol !== 0) begin errors++; $display("FAIL stall_stable_%0d: got %0d exp 0", pass, stall_viol); end
            checks++; if (occ_viol !== 0) begin errors++; $display("FAIL stall_occupancy_%0d: got %0d exp 0", pass, occ_viol); end
            checks++; if (same_viol + spur_sd !== 0) begin errors++; $display("FAIL stall_done_pulses_%0d: got %0d exp 0", pass, same_viol + spur_sd); end
        end
    endtask

    task automatic test_cfg_err();
        int t_nsc[4] = '{1190, 0, 5, 0};
        int t_nrb[4] = '{1, 1, 0, 1};
        int t_ss[4]  = '{0, 5, 0, 0};
        int t_se[4]  = '{1, 4, 1, 14};
        int e;
        for (int t = 0; t < 4; t++) begin
            clear_mon();
            @(posedge clk); #1;
            N_sc = 11'(t_nsc[t]); N_rb = 7'(t_nrb[t]);
            Sym_Start = 4'(t_ss[t]); Sym_End = 4'(t_se[t]);
            Start = 1'b1; EN_RE = 1'b1; Out_Ready = 1'b1;
            @(posedge clk); #1;
            Start = 1'b0;
            repeat (8) @(posedge clk);
            #1;
            checks++; if (cfg_cnt !== 1) begin errors++; $display("FAIL cfg_err_pulse_%0d: got %0d exp 1", t, cfg_cnt); end
            checks++; if (rd_cnt !== 0) begin errors++; $display("FAIL cfg_err_no_read_%0d: got %0d exp 0", t, rd_cnt); end
            checks++; if (busy_cnt !== 0) begin errors++; $display("FAIL cfg_err_busy_%0d: got %0d exp 0", t, busy_cnt); end
        end
        gseed = $urandom;
        build_exp(1188, 1, 0, 1);
        run_job(1188, 1, 0, 1, 2, 0, -1, 300);
        e = stream_errs();
        checks++; if (e !== 0 || cfg_cnt !== 0) begin errors++; $display("FAIL cfg_edge_1200: bad=%0d cfg_err=%0d exp 0 0", e, cfg_cnt); end
    endtask

    task automatic test_random();
        int nsc, nrb, ss, se, e;
        for (int j = 0; j < 6; j++) begin
            nrb = $urandom_range(1, 8);
            nsc = $urandom_range(0, 1200 - nrb * 12);
            ss  = $urandom_range(0, 12);
            se  = $urandom_range(ss + 1, 13);
            gseed = $urandom;
            build_exp(nsc, nrb, ss, se);
            run_job(nsc, nrb, ss, se, $urandom_range(0, 2), $urandom_range(0, 1), -1, 8000);
            e = stream_errs();
            checks++; if (e !== 0) begin errors++; $display("FAIL rand_stream_%0d: nsc=%0d nrb=%0d sym=%0d..%0d bad=%0d idx=%0d", j, nsc, nrb, ss, se, e, bad_idx); end
            checks++; if (sym_done_cnt !== se - ss + 1 || demap_cnt !== 1) begin errors++; $display("FAIL rand_done_%0d: sym_done=%0d demap=%0d exp %0d 1", j, sym_done_cnt, demap_cnt, se - ss + 1); end
            checks++; if (occ_viol + stall_viol !== 0) begin errors++; $display("FAIL rand_flow_%0d: got %0d exp 0", j, occ_viol + stall_viol); end
        end
    endtask

    task automatic test_full();
        int e;
        gseed = $urandom;
        build_exp(0, 100, 0, 13);
        run_job(0, 100, 0, 13, 0, 1, -1, 30000);
        checks++; if (got_q.size() !== 600 + 13 * 1200) begin errors++; $display("FAIL full_count: got %0d exp %0d", got_q.size(), 600 + 13 * 1200); end
        e = stream_errs();
        checks++; if (e !== 0) begin errors++; $display("FAIL full_stream: bad=%0d idx=%0d", e, bad_idx); end
        checks++; if (last_rd_addr !== 11'd1199 || last_rd_sym !== 4'd13) begin errors++; $display("FAIL full_last_read: got %0d/%0d exp 1199/13", last_rd_addr, last_rd_sym); end
        checks++; if (demap_cnt !== 1 || occ_viol !== 0) begin errors++; $display("FAIL full_done: demap=%0d occ_viol=%0d exp 1 0", demap_cnt, occ_viol); end
    endtask

    task automatic test_reset_mid();
        int n, e;
        logic reached;
        gseed = $urandom;
        clear_mon();
        @(posedge clk); #1;
        N_sc = 11'd0; N_rb = 7'd4; Sym_Start = 4'd0; Sym_End = 4'd3;
        Start = 1'b1; EN_RE = 1'b1;
        drive_modes(2, 0, 0);
        n = 0;
        reached = 1'b0;
        while (!reached && n < 3000) begin
            @(posedge clk); #1;
            Start = 1'b0;
            drive_modes(2, 0, n);
            reached = (got_q.size() > 0) && (got_q[got_q.size() - 1].sym != 4'd0);
            n++;
        end
        checks++; if (reached !== 1'b1) begin errors++; $display("FAIL rstmid_reach_data: got %b exp 1", reached); end
        RST_RE = 1'b1;
        @(posedge clk); #1;
        RST_RE = 1'b0; Out_Ready = 1'b1; EN_RE = 1'b1;
        @(negedge clk);
        checks++;
        if ({Rd_en, Rd_addr, Rd_sym, Out_I, Out_Q, Out_Addr, Out_Sym, Out_Is_Dmrs,
             Out_Valid, Sym_Done, Demap_Done, Busy, Cfg_Err} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: valid=%b busy=%b rd_en=%b, all required 0", Out_Valid, Busy, Rd_en);
        end
        build_exp(3, 2, 1, 4);
        run_job(3, 2, 1, 4, 2, 0, 6, 2000);
        e = stream_errs();
        checks++; if (e !== 0) begin errors++; $display("FAIL rstmid_next_stream: bad=%0d idx=%0d got_n=%0d exp_n=%0d", e, bad_idx, got_q.size(), exp_q.size()); end
        checks++; if (cfg_cnt !== 0 || demap_cnt !== 1) begin errors++; $display("FAIL busy_start_ignored: cfg_err=%0d demap=%0d exp 0 1", cfg_cnt, demap_cnt); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_odd_nsc();
        test_stall();
        test_cfg_err();
        test_random();
        test_full();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
